// File: rtl/rom_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rom_fetch_pkg
//  Shared definitions for the boot-ROM instruction fetcher:
//   - fetch_state_e : fetcher FSM states (BOOT / RUN / FAULT)
//   - fetch_entry_t : one buffered fetch result {pc, inst}
//   - NOP_INST      : value the ROM drives while held in reset
//   - default ROM window / FIFO sizing
//   - pc_in_rom()   : legality test for a fetch PC against the ROM window
// ---------------------------------------------------------------------------
package rom_fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_ROM_BASE = 32'h0000_0000;
   localparam int          DEFAULT_ADDR_W   = 9;
   localparam int          DEFAULT_DEPTH    = 2;

   // A PC is fetchable when word aligned and inside [base, base + 4*2**addr_w).
   // The subtraction wraps, so PCs below base land far above the window size.
   function automatic logic pc_in_rom(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input int          addr_w);
      logic [32:0] offset;
      logic [32:0] size_bytes;
      offset     = {1'b0, pc - base};
      size_bytes = 33'd4 << addr_w;
      return (pc[1:0] == 2'b00) && (offset < size_bytes);
   endfunction

endpackage

// File: rtl/rom_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//  Skid buffer between the ROM read pipeline and decode. Head is visible
//  combinationally (first-word fall-through) so decode sees an entry the
//  cycle after it is written.
//  Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         drop every entry; wins over push and pop
//   push          write push_data at the tail
//   push_data     {pc, inst} to store
//   pop           remove the head (caller only pops when valid)
//   head          current head entry; {0, NOP} while empty
//   valid         at least one entry stored
//   count         number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo
   import rom_fetch_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; count_q alone decides what is live.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign valid = (count_q != '0);
   assign count = count_q;
   assign head  = valid ? mem_q[rd_ptr_q] : '{pc: 32'h0, inst: NOP_INST};

endmodule

// File: rtl/rom_fetch.sv
// ---------------------------------------------------------------------------
// rom_fetch
//  Instruction fetcher for a synchronous boot ROM with one cycle of read
//  latency. Walks a byte PC through the ROM, buffers results in a small skid
//  FIFO and hands {pc, inst} to decode over valid/ready.
//  Ports:
//   clka         clock
//   rsta_n       asynchronous active-low reset
//   rom_rsta     ROM reset, high while the fetcher is in BOOT
//   rom_addra    ROM word address derived from fetch_pc (combinational)
//   rom_douta    ROM data, valid the cycle after a read was issued
//   redirect     one-cycle pulse restarting fetch at redirect_pc
//   redirect_pc  new byte PC
//   inst_valid   FIFO head holds an instruction
//   inst_ready   decode takes the head this cycle
//   inst_data    head instruction
//   inst_pc      head byte PC
//   fetch_fault  set while stopped on an illegal fetch PC; cleared by redirect
// ---------------------------------------------------------------------------
module rom_fetch
   import rom_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] ROM_BASE = DEFAULT_ROM_BASE,
   parameter int          ADDR_W   = DEFAULT_ADDR_W,
   parameter int          DEPTH    = DEFAULT_DEPTH
) (
   input  logic              clka,
   input  logic              rsta_n,
   output logic              rom_rsta,
   output logic [ADDR_W-1:0] rom_addra,
   input  logic [31:0]       rom_douta,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst_data,
   output logic [31:0]       inst_pc,
   output logic              fetch_fault
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e state_q,    state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  tag_pc_q,   tag_pc_d;
   logic         inflight_q, inflight_d;
   logic         fault_q,    fault_d;
   logic         rom_rsta_q, rom_rsta_d;

   logic             pop;
   logic             push;
   logic             flush;
   logic             take_redirect;
   logic             pc_legal;
   logic             redirect_legal;
   logic             credit_ok;
   logic             run_slot;
   logic             issue;
   logic             fifo_valid;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     fifo_head;
   fetch_entry_t     push_entry;

   assign rom_addra = ADDR_W'((fetch_pc_q - ROM_BASE) >> 2);

   assign pc_legal       = pc_in_rom(fetch_pc_q, ROM_BASE, ADDR_W);
   assign redirect_legal = pc_in_rom(redirect_pc, ROM_BASE, ADDR_W);

   // Redirects are only honoured once the ROM is out of reset.
   assign take_redirect = redirect && (state_q != ST_BOOT);
   assign flush         = take_redirect;
   assign pop           = fifo_valid && inst_ready;

   // A read may start only if its data is certain to find a FIFO slot:
   // entries already stored plus the one in flight, less the one leaving now.
   assign credit_ok = (int'(fifo_count) + int'(inflight_q) - int'(pop)) < DEPTH;
   assign run_slot  = (state_q == ST_RUN) && !take_redirect && credit_ok;
   assign issue     = run_slot && pc_legal;

   // The ROM answers the cycle after issue; a redirect discards that answer.
   assign push       = inflight_q && !take_redirect;
   assign push_entry = '{pc: tag_pc_q, inst: rom_douta};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      tag_pc_d   = tag_pc_q;
      inflight_d = issue;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            // A redirect from RUN always lands in RUN; an illegal target is
            // caught on the next issue attempt.
            if (!take_redirect && run_slot && !pc_legal) state_d = ST_FAULT;
         end
         ST_FAULT: begin
            if (take_redirect) state_d = redirect_legal ? ST_RUN : ST_FAULT;
         end
         default: state_d = ST_BOOT;
      endcase
      if (take_redirect) begin
         fetch_pc_d = redirect_pc;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         tag_pc_d   = fetch_pc_q;
      end
      fault_d    = (state_d == ST_FAULT);
      rom_rsta_d = (state_d == ST_BOOT);
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q    <= ST_BOOT;
         fetch_pc_q <= RESET_PC;
         tag_pc_q   <= 32'h0;
         inflight_q <= 1'b0;
         fault_q    <= 1'b0;
         rom_rsta_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         tag_pc_q   <= tag_pc_d;
         inflight_q <= inflight_d;
         fault_q    <= fault_d;
         rom_rsta_q <= rom_rsta_d;
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clka),
      .rst_n    (rsta_n),
      .flush    (flush),
      .push     (push),
      .push_data(push_entry),
      .pop      (pop),
      .head     (fifo_head),
      .valid    (fifo_valid),
      .count    (fifo_count)
   );

   assign rom_rsta    = rom_rsta_q;
   assign fetch_fault = fault_q;
   assign inst_valid  = fifo_valid;
   assign inst_data   = fifo_head.inst;
   assign inst_pc     = fifo_head.pc;

endmodule

// File: tb/tb_rom_fetch.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch
//  Bench for rom_fetch with a behavioural 512x32 ROM holding random words.
//  Directed steps cover start-up latency, backpressure, redirects, the end
//  of the ROM window and asynchronous reset; a random phase follows. Every
//  accepted transaction is compared with the expected PC stream: it starts
//  at the reset PC or the last redirect target and advances by 4 per accept,
//  and nothing may be accepted once that stream leaves the ROM window.
// ---------------------------------------------------------------------------
module tb_rom_fetch;

   logic        clka = 1'b0;
   logic        rsta_n;
   logic        rom_rsta;
   logic [8:0]  rom_addra;
   logic [31:0] rom_douta;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        fetch_fault;

   int n_cmp = 0;
   int n_err = 0;
   int n_acc = 0;

   logic [31:0] rom_mem [512];

   always #5 clka = ~clka;

   rom_fetch dut (
      .clka       (clka),
      .rsta_n     (rsta_n),
      .rom_rsta   (rom_rsta),
      .rom_addra  (rom_addra),
      .rom_douta  (rom_douta),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst_data  (inst_data),
      .inst_pc    (inst_pc),
      .fetch_fault(fetch_fault)
   );

   // Synchronous boot ROM: one cycle of latency, NOP while in reset.
   always @(posedge clka) begin
      rom_douta <= rom_rsta ? 32'h13 : rom_mem[rom_addra];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit legal_pc(input logic [31:0] pc);
      return (pc[1:0] == 2'b00) && (pc < 32'h800);
   endfunction

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      return rom_mem[pc[10:2]];
   endfunction

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic wait_valid(input int max_cycles);
      int n = 0;
      while (!inst_valid && n < max_cycles) begin
         step();
         n++;
      end
      check("valid_within_bound", {63'b0, inst_valid}, 64'd1);
   endtask

   // ---------------- transaction monitor / reference model ----------------
   logic [31:0] exp_pc     = 32'h0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_pc    = 32'h0;
   logic [31:0] prev_data  = 32'h0;

   always @(negedge clka) begin
      if (rsta_n !== 1'b1) begin
         exp_pc     = 32'h0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("head_hold", {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, prev_pc});
            check("data_hold", {32'b0, inst_data}, {32'b0, prev_data});
         end
         if (redirect) begin
            exp_pc     = redirect_pc;
            prev_stall = 1'b0;
         end else begin
            if (inst_valid && inst_ready) begin
               $display("accept pc=%08h data=%08h expected_pc=%08h", inst_pc, inst_data, exp_pc);
               check("acc_pc", {32'b0, inst_pc}, {32'b0, exp_pc});
               check("acc_pc_in_window", {63'b0, legal_pc(inst_pc)}, 64'd1);
               if (legal_pc(exp_pc)) begin
                  check("acc_data", {32'b0, inst_data}, {32'b0, rom_word(exp_pc)});
               end
               exp_pc = exp_pc + 32'd4;
               n_acc++;
            end
            prev_stall = inst_valid && !inst_ready;
            prev_pc    = inst_pc;
            prev_data  = inst_data;
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic [8:0] addr_snap;
      int         n;
      int         acc_before;

      rsta_n      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b0;
      for (int i = 0; i < 512; i++) rom_mem[i] = $urandom;

      // Reset state
      step();
      step();
      check("reset_valid", {63'b0, inst_valid}, 64'd0);
      check("reset_data",  {32'b0, inst_data}, 64'h13);
      check("reset_pc",    {32'b0, inst_pc}, 64'h0);
      check("reset_fault", {63'b0, fetch_fault}, 64'd0);
      check("reset_rom_rsta", {63'b0, rom_rsta}, 64'd1);

      // Release between edges; E1 is the next rising edge.
      @(posedge clka);
      #3;
      rsta_n     = 1'b1;
      inst_ready = 1'b1;
      step();   // E1
      check("boot_exit_rom_rsta", {63'b0, rom_rsta}, 64'd0);
      check("e1_valid", {63'b0, inst_valid}, 64'd0);
      step();   // E2
      check("e2_valid", {63'b0, inst_valid}, 64'd0);
      step();   // E3
      for (int i = 0; i < 3; i++) begin
         check("stream_pc",   {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, 32'(4 * i)});
         check("stream_data", {32'b0, inst_data}, {32'b0, rom_mem[i]});
         step();
      end

      // Asynchronous reset mid-stream, then backpressure from first valid.
      @(posedge clka);
      #3;
      rsta_n     = 1'b0;
      inst_ready = 1'b0;
      #1;
      check("async_rst_valid", {63'b0, inst_valid}, 64'd0);
      check("async_rst_rom_rsta", {63'b0, rom_rsta}, 64'd1);
      @(posedge clka);
      #3;
      rsta_n = 1'b1;
      step();
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         check("stall_head", {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, 32'h0});
         check("stall_data", {32'b0, inst_data}, {32'b0, rom_mem[0]});
         step();
      end
      check("stall_fetched_depth", {55'b0, rom_addra}, 64'd2);
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("resume_pc", {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, 32'(4 * i)});
         step();
      end

      // Redirect while a read is in flight.
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      check("redirect_flush", {63'b0, inst_valid}, 64'd0);
      wait_valid(10);
      check("redirect_pc",   {32'b0, inst_pc}, 64'h40);
      check("redirect_data", {32'b0, inst_data}, {32'b0, rom_mem[16]});

      // Run off the end of the ROM.
      redirect    = 1'b1;
      redirect_pc = 32'h7E0;
      step();
      redirect = 1'b0;
      n = 0;
      while (!(inst_valid && inst_pc == 32'h7FC) && n < 40) begin
         step();
         n++;
      end
      check("last_word_pc",   {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, 32'h7FC});
      check("last_word_data", {32'b0, inst_data}, {32'b0, rom_mem[511]});
      repeat (4) step();
      check("end_fault", {63'b0, fetch_fault}, 64'd1);
      check("end_valid", {63'b0, inst_valid}, 64'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h0;
      step();
      redirect = 1'b0;
      check("end_fault_cleared", {63'b0, fetch_fault}, 64'd0);
      wait_valid(10);
      check("end_restart_pc", {32'b0, inst_pc}, 64'h0);

      // Misaligned redirect target.
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect  = 1'b0;
      addr_snap = rom_addra;
      check("misaligned_addr", {55'b0, addr_snap}, 64'h40);
      repeat (4) step();
      check("misaligned_fault", {63'b0, fetch_fault}, 64'd1);
      check("misaligned_valid", {63'b0, inst_valid}, 64'd0);
      check("misaligned_addr_hold", {55'b0, rom_addra}, {55'b0, addr_snap});
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      check("recover_fault", {63'b0, fetch_fault}, 64'd0);
      wait_valid(10);
      check("recover_pc",   {32'b0, inst_pc}, 64'h100);
      check("recover_data", {32'b0, inst_data}, {32'b0, rom_mem[64]});

      // Random phase: random backpressure and redirect targets.
      acc_before = n_acc;
      for (int i = 0; i < 600; i++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         redirect   = 1'b0;
         if ($urandom_range(0, 24) == 0) begin
            redirect = 1'b1;
            case ($urandom_range(0, 9))
               7:       redirect_pc = 32'h7C0 + (32'($urandom_range(0, 15)) << 2);
               8:       redirect_pc = (32'($urandom_range(0, 511)) << 2) | 32'($urandom_range(1, 3));
               9:       redirect_pc = 32'h800 + (32'($urandom_range(0, 1000)) << 2);
               default: redirect_pc = 32'($urandom_range(0, 511)) << 2;
            endcase
         end
         step();
      end
      redirect   = 1'b0;
      inst_ready = 1'b1;
      repeat (5) step();
      check("random_progress", {63'b0, (n_acc > acc_before)}, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

endmodule
